// File: rtl/lock_pkg.sv
// ---------------------------------------------------------------------------
// lock_pkg
// Shared types and constants for the combination-lock sequencer.
//   state_t      : controller state encoding
//   phase_t      : 4-step latch command phase counter and its named steps
//   latch_cmd_t  : command currently presented to the gated RS latch
//   latch_sr()   : maps a latch command onto the {S,R} pin pair
//   DIGIT_W      : width of one keypad digit
// ---------------------------------------------------------------------------
package lock_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CMD_SET,
    OPEN,
    CMD_CLR,
    PENALTY,
    FAULT
  } state_t;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_DRIVE = 2'd0;  // S/R driven, gate closed
  localparam phase_t PH_PULSE = 2'd1;  // gate open
  localparam phase_t PH_HOLD  = 2'd2;  // gate closed, S/R still held
  localparam phase_t PH_CHECK = 2'd3;  // S/R released, read back Q

  typedef enum logic [1:0] {
    LATCH_HOLD,
    LATCH_SET,
    LATCH_CLR
  } latch_cmd_t;

  // Only one encoding per command, so S=R=1 cannot be produced.
  function automatic logic [1:0] latch_sr(input latch_cmd_t cmd);
    logic [1:0] sr;
    sr = 2'b00;
    case (cmd)
      LATCH_SET: sr = 2'b10;
      LATCH_CLR: sr = 2'b01;
      default:   sr = 2'b00;
    endcase
    return sr;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// ---------------------------------------------------------------------------
// lock_timer
// Loadable down-counter that saturates at zero and flags completion.
// Shared between the lockout penalty and the optional auto-relock timeout.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   load     : load load_val this cycle (has priority over en)
//   load_val : value to load
//   en       : decrement by one when nonzero
//   done     : count has reached zero
// ---------------------------------------------------------------------------
module lock_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lock_seq_ctrl.sv
// ---------------------------------------------------------------------------
// lock_seq_ctrl
// Combination-lock sequencer. Collects DIGITS keypad digits, compares them
// with CODE and drives the S/R/EN pins of the gated RS latch holding the
// lock state, verifying each latch command through the Q_fb read-back.
//
// Optional feature macro: LOCK_AUTORELOCK_EN
//   defined   : OPEN relocks by itself after OPEN_CYCLES cycles
//   undefined : OPEN persists until lock_req
//
// Ports
//   C         : clock, rising edge
//   RSTn      : asynchronous active-low reset
//   key_valid : one-cycle strobe, key valid this cycle
//   key       : digit 0-9 (10-15 never match)
//   lock_req  : relock request level, sampled each cycle
//   Q_fb      : latch Q read-back
//   S, R, EN  : latch set / reset / gate
//   unlocked  : high in OPEN
//   lockout   : high in PENALTY
//   fault     : latch read-back failure (held until reset)
// ---------------------------------------------------------------------------
module lock_seq_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned                 DIGITS         = 4,
  parameter logic [DIGITS*DIGIT_W-1:0]   CODE           = 16'h1234,
  parameter int unsigned                 MAX_TRIES      = 3,
  parameter int unsigned                 PENALTY_CYCLES = 100,
  parameter int unsigned                 OPEN_CYCLES    = 1000
) (
  input  logic               C,
  input  logic               RSTn,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key,
  input  logic               lock_req,
  input  logic               Q_fb,
  output logic               S,
  output logic               R,
  output logic               EN,
  output logic               unlocked,
  output logic               lockout,
  output logic               fault
);

  localparam int unsigned TRY_W  = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;
  localparam int unsigned DCNT_W = $clog2(DIGITS + 1);

  // The timer reloads with N-1 so that "done" falls on the N-th cycle.
  localparam int unsigned PEN_LOAD  = (PENALTY_CYCLES > 0) ? PENALTY_CYCLES - 1 : 0;
  localparam int unsigned OPEN_LOAD = (OPEN_CYCLES > 0) ? OPEN_CYCLES - 1 : 0;
  localparam int unsigned TMR_SPAN  = (PEN_LOAD > OPEN_LOAD) ? PEN_LOAD : OPEN_LOAD;
  localparam int unsigned TMR_W     = (TMR_SPAN > 0) ? $clog2(TMR_SPAN + 1) : 1;

  // FSM state
  state_t state, state_nxt;
  phase_t phase, phase_nxt;
  logic   retry, retry_nxt;

  // Datapath
  logic [DCNT_W-1:0] dig_cnt;
  logic              mismatch;
  logic [TRY_W-1:0]  tries;
  logic              cleared;

  // Control strobes from next-state logic
  logic             dig_ld;
  logic             dig_take;
  logic             tries_inc;
  logic             tries_clr;
  logic             cleared_set;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_en;
  logic             tmr_done;

  // Digit comparison
  logic [DCNT_W-1:0]  dig_idx;
  logic [DIGIT_W-1:0] exp_digit;
  logic               digit_bad;

  latch_cmd_t latch_cmd;

  // -------------------------------------------------------------------------
  // Shared timer: PENALTY and OPEN never overlap.
  // -------------------------------------------------------------------------
  lock_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk      (C),
    .rst_n    (RSTn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  // -------------------------------------------------------------------------
  // Expected digit lookup; first digit lives in the MS nibble of CODE.
  // -------------------------------------------------------------------------
  assign dig_idx = dig_ld ? '0 : dig_cnt;

  always_comb begin
    exp_digit = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (dig_idx == DCNT_W'(i)) begin
        exp_digit = CODE[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
      end
    end
  end

  assign digit_bad = (key > 4'd9) || (key != exp_digit);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge C or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      phase <= PH_DRIVE;
      retry <= 1'b0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      retry <= retry_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    retry_nxt   = retry;
    dig_ld      = 1'b0;
    dig_take    = 1'b0;
    tries_inc   = 1'b0;
    tries_clr   = 1'b0;
    cleared_set = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tmr_en      = 1'b0;

    unique case (state)
      IDLE: begin
        // The latch is cleared once after reset before any entry is taken.
        if (!cleared) begin
          state_nxt = CMD_CLR;
          phase_nxt = PH_DRIVE;
          retry_nxt = 1'b0;
        end else if (key_valid) begin
          dig_ld    = 1'b1;
          state_nxt = ENTRY;
        end
      end

      ENTRY: begin
        if (dig_cnt == DCNT_W'(DIGITS)) begin
          // Verdict cycle: keys arriving now are dropped.
          if (!mismatch) begin
            tries_clr = 1'b1;
            state_nxt = CMD_SET;
            phase_nxt = PH_DRIVE;
            retry_nxt = 1'b0;
          end else if (tries >= TRY_W'(MAX_TRIES - 1)) begin
            tries_clr = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = TMR_W'(PEN_LOAD);
            state_nxt = PENALTY;
          end else begin
            tries_inc = 1'b1;
            state_nxt = IDLE;
          end
        end else if (key_valid) begin
          dig_take = 1'b1;
        end
      end

      CMD_SET, CMD_CLR: begin
        if (phase != PH_CHECK) begin
          phase_nxt = phase + 2'd1;
        end else if (Q_fb == (state == CMD_SET)) begin
          if (state == CMD_SET) begin
            state_nxt = OPEN;
`ifdef LOCK_AUTORELOCK_EN
            tmr_load  = 1'b1;
            tmr_val   = TMR_W'(OPEN_LOAD);
`endif
          end else begin
            cleared_set = 1'b1;
            state_nxt   = IDLE;
          end
        end else if (!retry) begin
          retry_nxt = 1'b1;
          phase_nxt = PH_DRIVE;
        end else begin
          state_nxt = FAULT;
        end
      end

      OPEN: begin
`ifdef LOCK_AUTORELOCK_EN
        tmr_en = 1'b1;
`endif
        if (lock_req) begin
          state_nxt = CMD_CLR;
          phase_nxt = PH_DRIVE;
          retry_nxt = 1'b0;
        end
`ifdef LOCK_AUTORELOCK_EN
        else if (tmr_done) begin
          state_nxt = CMD_CLR;
          phase_nxt = PH_DRIVE;
          retry_nxt = 1'b0;
        end
`endif
      end

      PENALTY: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          state_nxt = IDLE;
        end
      end

      FAULT: begin
        state_nxt = FAULT;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Digit, try and startup-clear bookkeeping
  // -------------------------------------------------------------------------
  always_ff @(posedge C or negedge RSTn) begin
    if (!RSTn) begin
      dig_cnt  <= '0;
      mismatch <= 1'b0;
      tries    <= '0;
      cleared  <= 1'b0;
    end else begin
      if (dig_ld) begin
        dig_cnt  <= DCNT_W'(1);
        mismatch <= digit_bad;
      end else if (dig_take && (dig_cnt != DCNT_W'(DIGITS))) begin
        dig_cnt  <= dig_cnt + DCNT_W'(1);
        mismatch <= mismatch | digit_bad;
      end

      if (tries_clr) begin
        tries <= '0;
      end else if (tries_inc && (tries != TRY_W'(MAX_TRIES))) begin
        tries <= tries + TRY_W'(1);
      end

      if (cleared_set) begin
        cleared <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs, decoded from registered state so reset drops them at once.
  // -------------------------------------------------------------------------
  always_comb begin
    latch_cmd = LATCH_HOLD;
    if ((state == CMD_SET) && (phase != PH_CHECK)) begin
      latch_cmd = LATCH_SET;
    end else if ((state == CMD_CLR) && (phase != PH_CHECK)) begin
      latch_cmd = LATCH_CLR;
    end

    {S, R}   = latch_sr(latch_cmd);
    EN       = (latch_cmd != LATCH_HOLD) && (phase == PH_PULSE);
    unlocked = (state == OPEN);
    lockout  = (state == PENALTY);
    fault    = (state == FAULT);
  end

endmodule

// File: tb/tb_lock_seq_ctrl.sv
module tb_lock_seq_ctrl;

  logic       C = 1'b0;
  logic       RSTn = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key = 4'd0;
  logic       lock_req = 1'b0;
  logic       Q_fb;
  logic       S, R, EN, unlocked, lockout, fault;

  logic q_model = 1'b1;
  logic stuck0 = 1'b0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  localparam int EV_S      = 0;
  localparam int EV_R      = 1;
  localparam int EV_EN     = 2;
  localparam int EV_UNLK   = 3;
  localparam int EV_UNLK_F = 4;
  localparam int EV_LOCK   = 5;
  localparam int EV_LOCK_F = 6;
  localparam int EV_FAULT  = 7;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t exp_q[$];

  lock_seq_ctrl dut (
    .C         (C),
    .RSTn      (RSTn),
    .key_valid (key_valid),
    .key       (key),
    .lock_req  (lock_req),
    .Q_fb      (Q_fb),
    .S         (S),
    .R         (R),
    .EN        (EN),
    .unlocked  (unlocked),
    .lockout   (lockout),
    .fault     (fault)
  );

  always #5 C = ~C;

  always @(posedge C) cyc <= cyc + 1;

  // Gated RS latch model: captures while the gate is open.
  always @(posedge C) begin
    if (EN) begin
      if (S) q_model <= 1'b1;
      else if (R) q_model <= 1'b0;
    end
  end

  assign Q_fb = stuck0 ? 1'b0 : q_model;

  function automatic string ev_name(input int k);
    case (k)
      EV_S:      return "S_rise";
      EV_R:      return "R_rise";
      EV_EN:     return "EN_rise";
      EV_UNLK:   return "unlocked_rise";
      EV_UNLK_F: return "unlocked_fall";
      EV_LOCK:   return "lockout_rise";
      EV_LOCK_F: return "lockout_fall";
      EV_FAULT:  return "fault_rise";
      default:   return "unknown";
    endcase
  endfunction

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expect_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic got_ev(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got %s @%0d, required none", ev_name(kind), cyc);
    end else begin
      e = exp_q.pop_front();
      if ((e.kind != kind) || (e.at != cyc)) begin
        errors++;
        $display("FAIL event: got %s @%0d, required %s @%0d",
                 ev_name(kind), cyc, ev_name(e.kind), e.at);
      end
    end
  endtask

  task automatic monitor();
    logic ps = 1'b0, pr = 1'b0, pe = 1'b0, pu = 1'b0, pl = 1'b0, pf = 1'b0;
    forever begin
      @(negedge C);
      if (S && !ps)          got_ev(EV_S);
      if (R && !pr)          got_ev(EV_R);
      if (EN && !pe)         got_ev(EV_EN);
      if (unlocked && !pu)   got_ev(EV_UNLK);
      if (!unlocked && pu)   got_ev(EV_UNLK_F);
      if (lockout && !pl)    got_ev(EV_LOCK);
      if (!lockout && pl)    got_ev(EV_LOCK_F);
      if (fault && !pf)      got_ev(EV_FAULT);
      if ((S && R) || (EN && !(S ^ R))) begin
        errors++;
        $display("FAIL latch_encoding: got S=%b R=%b EN=%b, required legal (cycle %0d)",
                 S, R, EN, cyc);
      end
      ps = S; pr = R; pe = EN; pu = unlocked; pl = lockout; pf = fault;
    end
  endtask

  task automatic send_keys(input logic [3:0] k0, input logic [3:0] k1,
                           input logic [3:0] k2, input logic [3:0] k3,
                           output int tl);
    logic [3:0] ks [4];
    ks = '{k0, k1, k2, k3};
    tl = cyc;
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1;
      key       = ks[i];
      tl        = cyc;
      tick();
    end
    key_valid = 1'b0;
  endtask

  task automatic expect_unlock(input int tl);
    expect_ev(EV_S, tl + 2);
    expect_ev(EV_EN, tl + 3);
    expect_ev(EV_UNLK, tl + 6);
  endtask

  task automatic relock(output int t);
    lock_req = 1'b1;
    t = cyc;
    expect_ev(EV_R, t + 1);
    expect_ev(EV_UNLK_F, t + 1);
    expect_ev(EV_EN, t + 2);
    tick();
    lock_req = 1'b0;
  endtask

  task automatic release_reset(output int t0);
    RSTn = 1'b1;
    t0 = cyc;
    expect_ev(EV_R, t0 + 1);
    expect_ev(EV_EN, t0 + 2);
  endtask

  initial begin
    int t0, tl, tk, t, topen;

    fork
      monitor();
    join_none

    #1 RSTn = 1'b0;
    repeat (3) tick();
    check1("reset_S", S, 1'b0);
    check1("reset_R", R, 1'b0);
    check1("reset_EN", EN, 1'b0);
    check1("reset_unlocked", unlocked, 1'b0);
    check1("reset_lockout", lockout, 1'b0);
    check1("reset_fault", fault, 1'b0);

    // Startup clear, then correct code.
    release_reset(t0);
    wait_until(t0 + 8);
    send_keys(4'd1, 4'd2, 4'd3, 4'd4, tl);
    expect_unlock(tl);
    wait_until(tl + 8);
    check1("open_after_code", unlocked, 1'b1);

    // lock_req and key together in OPEN: relock wins, key dropped.
    key_valid = 1'b1;
    key       = 4'd9;
    relock(t);
    key_valid = 1'b0;
    wait_until(t + 7);
    check1("closed_after_relock", unlocked, 1'b0);
    send_keys(4'd1, 4'd2, 4'd3, 4'd4, tl);
    expect_unlock(tl);
    wait_until(tl + 8);
    relock(t);
    wait_until(t + 7);

    // Three wrong entries -> lockout for 100 cycles.
    for (int a = 0; a < 3; a++) begin
      send_keys(4'd1, 4'd2, 4'd3, 4'd5, tl);
      if (a == 2) begin
        expect_ev(EV_LOCK, tl + 2);
        expect_ev(EV_LOCK_F, tl + 102);
      end
      wait_until(tl + 3);
    end
    wait_until(tl + 50);
    check1("lockout_mid", lockout, 1'b1);
    send_keys(4'd1, 4'd2, 4'd3, 4'd4, tk);
    wait_until(tl + 104);
    check1("lockout_done", lockout, 1'b0);
    check1("locked_after_penalty", unlocked, 1'b0);

    // Digit 0xF inside a sequence counts as wrong.
    send_keys(4'd1, 4'd2, 4'hF, 4'd4, tl);
    wait_until(tl + 8);
    check1("bad_digit_locked", unlocked, 1'b0);

    send_keys(4'd1, 4'd2, 4'd3, 4'd4, tl);
    expect_unlock(tl);
    topen = tl + 6;
`ifdef LOCK_AUTORELOCK_EN
    expect_ev(EV_R, topen + 1000);
    expect_ev(EV_UNLK_F, topen + 1000);
    expect_ev(EV_EN, topen + 1001);
    wait_until(topen + 2000);
    check1("autorelocked", unlocked, 1'b0);
`else
    wait_until(topen + 2000);
    check1("still_open_2000", unlocked, 1'b1);
    relock(t);
    wait_until(t + 7);
`endif

    // Read-back stuck at 0: one retry, then FAULT.
    stuck0 = 1'b1;
    send_keys(4'd1, 4'd2, 4'd3, 4'd4, tl);
    expect_ev(EV_S, tl + 2);
    expect_ev(EV_EN, tl + 3);
    expect_ev(EV_S, tl + 6);
    expect_ev(EV_EN, tl + 7);
    expect_ev(EV_FAULT, tl + 10);
    wait_until(tl + 12);
    check1("fault_set", fault, 1'b1);
    send_keys(4'd1, 4'd2, 4'd3, 4'd4, tk);
    lock_req = 1'b1;
    repeat (3) tick();
    lock_req = 1'b0;
    repeat (40) tick();
    check1("fault_sticky", fault, 1'b1);

    // Reset leaves FAULT.
    stuck0 = 1'b0;
    RSTn = 1'b0;
    #1;
    check1("fault_cleared_by_reset", fault, 1'b0);
    repeat (2) tick();
    release_reset(t0);
    wait_until(t0 + 8);

    // Reset during the enable pulse drops S/R/EN immediately.
    send_keys(4'd1, 4'd2, 4'd3, 4'd4, tl);
    expect_ev(EV_S, tl + 2);
    expect_ev(EV_EN, tl + 3);
    wait_until(tl + 3);
    #5;
    RSTn = 1'b0;
    #1;
    check1("async_S", S, 1'b0);
    check1("async_R", R, 1'b0);
    check1("async_EN", EN, 1'b0);
    tick();
    tick();
    release_reset(t0);
    wait_until(t0 + 8);

    check1("scoreboard_drained", exp_q.size() == 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
